// File: rtl/cdc_tx_arbiter.sv
// rtl/cdc_tx_arbiter.sv - round-robin scheduler feeding one shared slow-to-fast CDC channel
// Launches one requester word per pulse, then holds the channel idle for a guard gap.
module cdc_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 3,
  localparam int TAG_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [DATA_WIDTH-1:0]         cdc_din_o,
  output logic [TAG_W-1:0]              cdc_tag_o,
  output logic                          cdc_valid_o,
  output logic                          busy_o
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [TAG_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic                    valid_q, valid_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;

  logic [DATA_WIDTH-1:0]   words [NUM_REQ];
  logic                    found;
  logic [TAG_W-1:0]        win_tag;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Rotating priority: scan upward from ptr_q with wrap, first set bit wins.
  always_comb begin
    int               idx;
    logic [TAG_W-1:0] sel;
    found   = 1'b0;
    win_tag = '0;
    idx     = 0;
    sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      sel = TAG_W'(idx);
      if (!found && req_i[sel]) begin
        found   = 1'b1;
        win_tag = sel;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    tag_d   = tag_q;
    valid_d = 1'b0;
    grant_d = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          din_d            = words[win_tag];
          tag_d            = win_tag;
          valid_d          = 1'b1;
          grant_d[win_tag] = 1'b1;
          state_d          = LAUNCH;
        end
      end
      LAUNCH: begin
        ptr_d   = (tag_q == LAST_TAG) ? '0 : tag_q + 1'b1;
        cnt_d   = CNT_W'(GAP_CYCLES - 1);
        state_d = GAP;
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o     = grant_q;
  assign cdc_din_o   = din_q;
  assign cdc_tag_o   = tag_q;
  assign cdc_valid_o = valid_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// tb/tb_cdc_tx_arbiter.sv - self-checking bench for cdc_tx_arbiter
module tb_cdc_tx_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 3;
  localparam int TW  = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant;
  logic [DW-1:0]   din;
  logic [TW-1:0]   tag;
  logic            valid;
  logic            busy;

  cdc_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .req_data_i  (req_data),
    .grant_o     (grant),
    .cdc_din_o   (din),
    .cdc_tag_o   (tag),
    .cdc_valid_o (valid),
    .busy_o      (busy)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] din;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [TW-1:0]   tag;
    logic [DW-1:0]   din;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks;
  int   errors;
  int   cyc;
  int   launches;
  int   last_v;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (!rst_n) return;
    if (valid) begin
      launches++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tag", 32'(tag), 32'(e.tag));
        chk("din", 32'(din), 32'(e.din));
        chk("grant", 32'(grant), 32'(1) << e.tag);
        chk("launch_cycle", cyc, e.cyc);
      end
      if (last_v >= 0) chk("min_spacing", 32'(cyc - last_v >= GAP + 2), 32'd1);
      last_v = cyc;
    end else begin
      chk("grant_without_valid", 32'(grant), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic expect_launch(input logic [TW-1:0] t, input logic [DW-1:0] d, input int at);
    exp_t e;
    e.tag = t;
    e.din = d;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic wait_launches(input int target);
    int b;
    b = 0;
    while (launches < target && b < 40) begin
      step();
      b++;
    end
    chk("launch_timeout", 32'(launches >= target), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_grant"}, 32'(grant), 32'd0);
    chk({name, "_valid"}, 32'(valid), 32'd0);
    chk({name, "_din"}, 32'(din), 32'd0);
    chk({name, "_tag"}, 32'(tag), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    launches = 0;
    last_v   = -1;

    vecs[0] = '{4'b0100, 32'h13A51110, 2'd2, 8'hA5};
    vecs[1] = '{4'b0101, 32'h44332211, 2'd0, 8'h11};
    vecs[2] = '{4'b0101, 32'h44332211, 2'd2, 8'h33};
    vecs[3] = '{4'b1000, 32'hDEADBEEF, 2'd3, 8'hDE};
    vecs[4] = '{4'b0011, 32'h0000FF01, 2'd0, 8'h01};
    vecs[5] = '{4'b0011, 32'h0000FF01, 2'd1, 8'hFF};
    vecs[6] = '{4'b0011, 32'h00008001, 2'd0, 8'h01};
    vecs[7] = '{4'b1110, 32'h77665544, 2'd1, 8'h55};
    vecs[8] = '{4'b1010, 32'h77665544, 2'd3, 8'h77};

    // Reset with every requester active: nothing may launch.
    rst_n    = 1'b0;
    req      = 4'b1111;
    req_data = 32'h13121110;
    repeat (3) step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    expect_launch(2'd0, 8'h10, cyc + 1);
    step();
    req = '0;
    repeat (GAP + 1) step();

    // Table: each vector starts in IDLE with a known pointer.
    for (int i = 0; i < 9; i++) begin
      req_data = vecs[i].data;
      req      = vecs[i].req;
      expect_launch(vecs[i].tag, vecs[i].din, cyc + 1);
      wait_launches(launches + 1);
      chk("busy_launch", 32'(busy), 32'd1);
      req = '0;
      for (int g = 0; g < GAP; g++) begin
        step();
        chk("busy_gap", 32'(busy), 32'd1);
      end
      step();
      chk("busy_idle", 32'(busy), 32'd0);
    end

    // Continuous requests: strict rotation, one pulse every GAP+2 cycles.
    req_data = 32'h13121110;
    req      = 4'b1111;
    base     = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      expect_launch(TW'(k % N), 8'h10 + 8'(k % N), base + k * (GAP + 2));
    end
    wait_launches(launches + 5);
    req = '0;
    repeat (GAP + 1) step();

    // Withdrawn request: captured word goes out once, never relaunched.
    req_data = 32'h00005C00;
    req      = 4'b0010;
    expect_launch(2'd1, 8'h5C, cyc + 1);
    step();
    req      = '0;
    req_data = 32'h0000FF00;
    repeat (8) step();
    chk("withdraw_din_hold", 32'(din), 32'h5C);
    chk("withdraw_drained", 32'(sb.size()), 32'd0);

    // Reset during GAP: abort, then serve fresh from pointer 0.
    req_data = 32'h13A51110;
    req      = 4'b0100;
    expect_launch(2'd2, 8'hA5, cyc + 1);
    step();
    req = 4'b1100;
    step();
    chk("midgap_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midgap_reset");
    last_v = -1;
    repeat (2) step();
    chk_reset_outputs("midgap_held");
    rst_n = 1'b1;
    expect_launch(2'd2, 8'hA5, cyc + 1);
    step();
    req = '0;
    repeat (GAP + 3) step();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("total_launches", launches, 32'd18);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
